// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulation sequencer and the
// accumulator instance it drives.
package acc_pkg;

  // Partial-sum / accumulator word width.
  localparam int ACC_W = 15;

  // Default feature-map geometry, shared with the accumulator RAM.
  localparam int DEF_DEPTH    = 114 * 114;
  localparam int DEF_ADDR_BIT = 14;
  localparam int DEF_PASS_BIT = 8;

  // Sequencer job state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_pass_ctrl_if.sv
// Bundle of the job-control, partial-sum stream, accumulator-control and
// result signals around the accumulation sequencer.
interface acc_pass_ctrl_if
  import acc_pkg::*;
#(
  parameter int ADDR_BIT = DEF_ADDR_BIT,
  parameter int PASS_BIT = DEF_PASS_BIT
);

  logic                start;
  logic [PASS_BIT-1:0] num_pass;
  logic                in_valid;
  logic                in_ready;
  logic [ACC_W-1:0]    in_data;
  logic                in_zero;
  logic                read_en;
  logic [ADDR_BIT-1:0] read_addr;
  logic                write_en;
  logic [ADDR_BIT-1:0] write_addr;
  logic [ACC_W-1:0]    acc_data;
  logic                prev_data_zero;
  logic                curr_data_zero;
  logic                result_valid;
  logic [ADDR_BIT-1:0] result_addr;
  logic                busy;
  logic                done;

  // Sequencer side.
  modport master (
    input  start, num_pass, in_valid, in_data, in_zero,
    output in_ready, read_en, read_addr, write_en, write_addr, acc_data,
           prev_data_zero, curr_data_zero, result_valid, result_addr,
           busy, done
  );

  // Environment side: PE array, accumulator and downstream stage.
  modport slave (
    output start, num_pass, in_valid, in_data, in_zero,
    input  in_ready, read_en, read_addr, write_en, write_addr, acc_data,
           prev_data_zero, curr_data_zero, result_valid, result_addr,
           busy, done
  );

endinterface

// File: rtl/acc_align_pipe.sv
// Shift register that carries each accepted beat alongside the RAM read and
// adder register, exposing the stage aligned with RAM dout and the stage
// aligned with the registered adder output.
module acc_align_pipe
  import acc_pkg::*;
#(
  parameter int ADDR_BIT = DEF_ADDR_BIT,
  parameter int STAGES   = 2,
  parameter int RD_TAP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [ADDR_BIT-1:0] in_addr,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [ACC_W-1:0]    in_data,
  input  logic                in_zero,
  output logic                rd_vld,
  output logic                rd_first,
  output logic [ACC_W-1:0]    rd_data,
  output logic                rd_zero,
  output logic                wr_vld,
  output logic [ADDR_BIT-1:0] wr_addr,
  output logic                wr_last
);

  typedef struct packed {
    logic                vld;
    logic [ADDR_BIT-1:0] addr;
    logic                first;
    logic                last;
    logic [ACC_W-1:0]    data;
    logic                zero;
  } beat_t;

  beat_t beat_p [STAGES];

  // Advance every stage each cycle; bubbles travel as vld = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) beat_p[i] <= '0;
    end else begin
      beat_p[0] <= '{vld: in_vld, addr: in_addr, first: in_first,
                     last: in_last, data: in_data, zero: in_zero};
      for (int i = 1; i < STAGES; i++) beat_p[i] <= beat_p[i-1];
    end
  end

  // Tap aligned with RAM dout
  assign rd_vld   = beat_p[RD_TAP-1].vld;
  assign rd_first = beat_p[RD_TAP-1].first;
  assign rd_data  = beat_p[RD_TAP-1].data;
  assign rd_zero  = beat_p[RD_TAP-1].zero;

  // Tap aligned with the registered adder output
  assign wr_vld  = beat_p[STAGES-1].vld;
  assign wr_addr = beat_p[STAGES-1].addr;
  assign wr_last = beat_p[STAGES-1].last;

endmodule

// File: rtl/acc_pass_ctrl.sv
// Accumulation sequencer: walks NUM_PASS partial-sum streams over a DEPTH-pixel
// buffer, driving the accumulator read/add/write-back and flagging final sums.
module acc_pass_ctrl
  import acc_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_BIT = DEF_ADDR_BIT,
  parameter int PASS_BIT = DEF_PASS_BIT,
  parameter int RD_LAT   = 1,
  parameter int ACC_LAT  = 1
) (
  input logic           clk,
  input logic           rst,
  acc_pass_ctrl_if.master bus
);

  localparam int STAGES  = RD_LAT + ACC_LAT;
  localparam int DRAIN_W = $clog2(STAGES + 1);
  localparam logic [ADDR_BIT-1:0] LAST_PIX  = ADDR_BIT'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_END = DRAIN_W'(STAGES - 1);

  state_t              state, state_nxt;
  logic [ADDR_BIT-1:0] pix;
  logic [PASS_BIT-1:0] pass_cnt;
  logic [PASS_BIT-1:0] pass_total;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                accept;
  logic                pix_wrap;
  logic                last_pass;
  logic                final_beat;

  logic                rd_vld, rd_first, rd_zero;
  logic [ACC_W-1:0]    rd_data;
  logic                wr_vld, wr_last;
  logic [ADDR_BIT-1:0] wr_addr;

  assign accept     = (state == RUN) && bus.in_valid;
  assign pix_wrap   = (pix == LAST_PIX);
  assign last_pass  = (pass_cnt == pass_total - PASS_BIT'(1));
  assign final_beat = accept && pix_wrap && last_pass;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only counts in IDLE; drain covers the read+add latency.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (final_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_END) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel/pass counters and drain timer; pass 0 of a job is loaded on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix        <= '0;
      pass_cnt   <= '0;
      pass_total <= '0;
      drain_cnt  <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        pix        <= '0;
        pass_cnt   <= '0;
        pass_total <= (bus.num_pass == '0) ? PASS_BIT'(1) : bus.num_pass;
      end else if (accept) begin
        if (pix_wrap) begin
          pix      <= '0;
          pass_cnt <= pass_cnt + PASS_BIT'(1);
        end else begin
          pix <= pix + ADDR_BIT'(1);
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  acc_align_pipe #(
    .ADDR_BIT (ADDR_BIT),
    .STAGES   (STAGES),
    .RD_TAP   (RD_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (accept),
    .in_addr  (pix),
    .in_first (pass_cnt == '0),
    .in_last  (last_pass),
    .in_data  (bus.in_data),
    .in_zero  (bus.in_zero),
    .rd_vld   (rd_vld),
    .rd_first (rd_first),
    .rd_data  (rd_data),
    .rd_zero  (rd_zero),
    .wr_vld   (wr_vld),
    .wr_addr  (wr_addr),
    .wr_last  (wr_last)
  );

  // Stream handshake and RAM read issue
  assign bus.in_ready  = (state == RUN);
  assign bus.read_en   = accept;
  assign bus.read_addr = accept ? pix : '0;

  // Adder operands: first-pass beats ignore whatever the RAM still holds.
  assign bus.acc_data       = rd_data;
  assign bus.prev_data_zero = rd_vld & rd_first;
  assign bus.curr_data_zero = rd_vld & rd_zero;

  // Write-back and final-result flag
  assign bus.write_en     = wr_vld;
  assign bus.write_addr   = wr_addr;
  assign bus.result_valid = wr_vld & wr_last;
  assign bus.result_addr  = wr_addr;

  assign bus.busy = (state == RUN) || (state == DRAIN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_acc_pass_ctrl.sv
// Bench for acc_pass_ctrl with a behavioural accumulator (1-cycle RAM read,
// 1-cycle adder register) at DEPTH = 4; final sums go through a scoreboard.
module tb_acc_pass_ctrl;

  localparam int DEPTH    = 4;
  localparam int ADDR_BIT = 2;
  localparam int PASS_BIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_pass_ctrl_if #(.ADDR_BIT(ADDR_BIT), .PASS_BIT(PASS_BIT)) bus ();

  acc_pass_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_BIT (ADDR_BIT),
    .PASS_BIT (PASS_BIT),
    .RD_LAT   (1),
    .ACC_LAT  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Accumulator: registered RAM read, registered adder, write-back of the sum.
  logic [14:0] ram [DEPTH];
  logic [14:0] dout;
  logic [14:0] acc_result;

  always @(posedge clk) if (bus.read_en) dout <= ram[bus.read_addr];

  always @(posedge clk or posedge rst)
    if (rst) acc_result <= '0;
    else     acc_result <= (bus.prev_data_zero ? 15'd0 : dout) +
                           (bus.curr_data_zero ? 15'd0 : bus.acc_data);

  always @(posedge clk) if (bus.write_en) ram[bus.write_addr] <= acc_result;

  // Scoreboard
  typedef struct packed {
    logic [ADDR_BIT-1:0] addr;
    logic [14:0]         val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats, reads, writes, done_cnt, last_beat_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts handshakes and compares every presented final sum.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        beats++;
        last_beat_cyc = cyc;
      end
      if (bus.read_en) reads++;
      if (bus.write_en) begin
        writes++;
        checks++;
        if (writes > reads) begin
          failures++;
          $display("FAIL write_without_read writes=%0d reads=%0d required writes<=reads",
                   writes, reads);
        end
      end
      if (bus.result_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result addr=%0d value=%0d required no result",
                   bus.result_addr, acc_result);
        end else begin
          e = exp_q.pop_front();
          if (bus.result_addr !== e.addr || acc_result !== e.val) begin
            failures++;
            $display("FAIL result addr=%0d value=%0d required addr=%0d value=%0d",
                     bus.result_addr, acc_result, e.addr, e.val);
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        checks++;
        if (cyc != last_beat_cyc + 3) begin
          failures++;
          $display("FAIL done_latency cycles=%0d required=3", cyc - last_beat_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic start_job(input logic [PASS_BIT-1:0] np);
    bus.start    = 1'b1;
    bus.num_pass = np;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input int d, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 15'(d);
    bus.in_zero  = (d == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    else tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, int'(bus.done), 1);
    check({name, "_busy_at_done"}, int'(bus.busy), 0);
    tick();
    check({name, "_done_one_cycle"}, int'(bus.done), 0);
  endtask

  task automatic run_job(input string name, input logic [PASS_BIT-1:0] np,
                         input int passes, input int d[4], input int exp[4],
                         input bit gaps, input bit perturb);
    beats = 0; reads = 0; writes = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back('{addr: ADDR_BIT'(i), val: 15'(exp[i])});
    start_job(np);
    check({name, "_busy"}, int'(bus.busy), 1);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (perturb && p == 0 && i == 2) begin
          bus.start    = 1'b1;
          bus.num_pass = 8'd9;
        end
        send_beat(d[i], gaps);
        bus.start = 1'b0;
      end
    end
    wait_done(name);
    check({name, "_beats"}, beats, passes * DEPTH);
    check({name, "_writes_eq_beats"}, writes, beats);
    check({name, "_reads_eq_beats"}, reads, beats);
    check({name, "_results_left"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_cnt, 1);
  endtask

  function automatic int outs_word();
    return int'({bus.in_ready, bus.read_en, bus.read_addr, bus.write_en,
                 bus.write_addr, bus.acc_data, bus.prev_data_zero,
                 bus.curr_data_zero, bus.result_valid, bus.result_addr,
                 bus.busy, bus.done});
  endfunction

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.num_pass = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_zero  = 1'b0;
    beats = 0; reads = 0; writes = 0; done_cnt = 0; last_beat_cyc = 0;
    repeat (3) tick();
    check("reset_outputs", outs_word(), 0);
    rst = 1'b0;
    tick();

    // Abort a two-pass job after two beats with an asynchronous reset.
    start_job(8'd2);
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    check("abort_busy_before", int'(bus.busy), 1);
    check("abort_acc_data_before", int'(bus.acc_data), 20);
    rst = 1'b1;
    #1;
    check("abort_outputs_zero", outs_word(), 0);
    check("abort_busy", int'(bus.busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_job("post_reset", 8'd1, 1, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 1'b0, 1'b0);
    run_job("three_pass", 8'd3, 3, '{1, 2, 3, 4}, '{3, 6, 9, 12}, 1'b0, 1'b0);
    run_job("stale_fill", 8'd1, 1, '{100, 100, 100, 100}, '{100, 100, 100, 100}, 1'b0, 1'b0);
    run_job("stale_mask", 8'd2, 2, '{1, 1, 1, 1}, '{2, 2, 2, 2}, 1'b0, 1'b0);
    run_job("zero_pass", 8'd0, 1, '{5, 6, 7, 8}, '{5, 6, 7, 8}, 1'b0, 1'b0);
    run_job("gaps", 8'd2, 2, '{1, 2, 3, 4}, '{2, 4, 6, 8}, 1'b1, 1'b0);

    // in_valid while idle must be refused.
    bus.in_valid = 1'b1;
    bus.in_data  = 15'd77;
    tick();
    check("idle_in_ready", int'(bus.in_ready), 0);
    check("idle_read_en", int'(bus.read_en), 0);
    tick();
    check("idle_busy", int'(bus.busy), 0);
    bus.in_valid = 1'b0;
    tick();

    run_job("perturb", 8'd2, 2, '{1, 2, 3, 4}, '{2, 4, 6, 8}, 1'b0, 1'b1);

    repeat (3) tick();
    check("final_idle_busy", int'(bus.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
